// File: rtl/usermem_io.sv
// User-memory bus responder: 240-byte RAM plus a 16-byte I/O page holding a
// prescaled down-counting timer, a pending/enable interrupt and a GPIO port.
module usermem_io #(
    parameter int unsigned PRESCALE = 16,
    parameter logic [7:0]  IO_BASE  = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       interrupt,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out
);

    localparam int unsigned DW        = 8;
    localparam int unsigned RAM_DEPTH = 32'(IO_BASE);
    localparam int unsigned IO_SIZE   = 16;
    localparam logic [DW-1:0] PRE_MAX = DW'(PRESCALE - 1);

    logic [DW-1:0] ram [RAM_DEPTH];

    logic [DW-1:0] reload;
    logic [DW-1:0] count;
    logic          en;
    logic          ie;
    logic          auto_rld;
    logic          pend;
    logic [DW-1:0] gpio_q;
    logic [DW-1:0] sync1;
    logic [DW-1:0] sync2;
    logic [DW-1:0] pre;

    logic          is_io;
    logic [DW-1:0] off;
    logic          wr_reload;
    logic          wr_ctrl;
    logic          wr_status;
    logic          wr_gpio;
    logic          tick;
    logic          timer_event;
    logic          en_next;

    // Address decode
    always_comb begin
        is_io     = (address >= IO_BASE);
        off       = address - IO_BASE;
        wr_reload = rw && is_io && (off == 8'd0);
        wr_ctrl   = rw && is_io && (off == 8'd2);
        wr_status = rw && is_io && (off == 8'd3);
        wr_gpio   = rw && is_io && (off == 8'd4);
    end

    // A CTRL write overrides the one-shot auto-disable on the same edge
    always_comb begin
        tick        = en && (pre == PRE_MAX);
        timer_event = tick && (count == 8'd0);
        en_next     = en;
        if (wr_ctrl) begin
            en_next = data_in[0];
        end else if (timer_event && !auto_rld) begin
            en_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            reload   <= '0;
            count    <= '0;
            en       <= 1'b0;
            ie       <= 1'b0;
            auto_rld <= 1'b0;
            pend     <= 1'b0;
            gpio_q   <= '0;
            sync1    <= '0;
            sync2    <= '0;
            pre      <= '0;
        end else begin
            en <= en_next;
            if (wr_ctrl) begin
                ie       <= data_in[1];
                auto_rld <= data_in[2];
            end

            if (!en || !en_next || tick) begin
                pre <= '0;
            end else begin
                pre <= pre + 8'd1;
            end

            if (wr_reload) begin
                reload <= data_in;
            end

            // Register write beats the tick; count never wraps below zero
            if (wr_reload) begin
                count <= data_in;
            end else if (tick) begin
                if (count != 8'd0) begin
                    count <= count - 8'd1;
                end else if (auto_rld) begin
                    count <= reload;
                end
            end

            if (timer_event) begin
                pend <= 1'b1;
            end else if (wr_status && data_in[0]) begin
                pend <= 1'b0;
            end

            if (wr_gpio) begin
                gpio_q <= data_in;
            end

            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

    // RAM has no reset
    always_ff @(posedge clk) begin
        if (rw && !is_io) begin
            ram[address] <= data_in;
        end
    end

    // Side-effect-free read mux
    always_comb begin
        data_out = '0;
        if (!is_io) begin
            data_out = ram[address];
        end else if (off < 8'(IO_SIZE)) begin
            unique case (off[3:0])
                4'd0:    data_out = reload;
                4'd1:    data_out = count;
                4'd2:    data_out = {5'd0, auto_rld, ie, en};
                4'd3:    data_out = {7'd0, pend};
                4'd4:    data_out = gpio_q;
                4'd5:    data_out = sync2;
                default: data_out = '0;
            endcase
        end
    end

    assign interrupt = pend && ie;
    assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_usermem_io.sv
// Directed bench for usermem_io with PRESCALE=4: RAM, timer, interrupt and GPIO.
module tb_usermem_io;

    logic       clk;
    logic       reset;
    logic [7:0] address;
    logic [7:0] data_in;
    logic       rw;
    logic [7:0] data_out;
    logic       interrupt;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;

    int checks = 0;
    int errors = 0;

    usermem_io #(.PRESCALE(4), .IO_BASE(8'hF0)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data_in   (data_in),
        .rw        (rw),
        .data_out  (data_out),
        .interrupt (interrupt),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Write edge is the first rising edge after the next falling edge
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        rw      = 1'b1;
        @(posedge clk);
        #1;
        rw = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        address = a;
        #1;
        check(tag, data_out, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {7'd0, interrupt}, {7'd0, exp});
    endtask

    initial begin
        reset   = 1'b0;
        rw      = 1'b0;
        address = 8'h00;
        data_in = 8'h00;
        gpio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state of the I/O page and outputs
        for (int a = 16'hF0; a <= 16'hFF; a++) begin
            rd("io_reset", 8'(a), 8'h00);
        end
        chk_irq("irq_reset", 1'b0);
        check("gpio_out_reset", gpio_out, 8'h00);

        // RAM boundaries and unmapped I/O
        wr(8'h00, 8'hA5);
        wr(8'hEF, 8'h3C);
        wr(8'hF6, 8'h77);
        rd("ram_00", 8'h00, 8'hA5);
        rd("ram_ef", 8'hEF, 8'h3C);
        rd("io_f6", 8'hF6, 8'h00);

        // Register masks and read-only COUNT
        wr(8'hF2, 8'hF8);
        rd("ctrl_mask", 8'hF2, 8'h00);
        wr(8'hF1, 8'h55);
        rd("count_ro", 8'hF1, 8'h00);

        // Auto-reload: period (2+1)*4 = 12 cycles
        wr(8'hF0, 8'h02);
        rd("reload_rd", 8'hF0, 8'h02);
        rd("count_load", 8'hF1, 8'h02);
        wr(8'hF2, 8'h07);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            chk_irq($sformatf("irq_first_%0d", i), i == 12);
        end
        wr(8'hF3, 8'h01);
        chk_irq("irq_cleared", 1'b0);
        for (int i = 14; i <= 24; i++) begin
            @(posedge clk);
            #1;
            chk_irq($sformatf("irq_second_%0d", i), i == 24);
        end
        // Clear on the same edge as the third event
        repeat (11) @(posedge clk);
        wr(8'hF3, 8'h01);
        chk_irq("irq_clear_vs_event", 1'b1);
        rd("status_clear_vs_event", 8'hF3, 8'h01);
        rd("count_reloaded", 8'hF1, 8'h02);

        // One-shot: RELOAD=1 gives an event after 8 cycles, then stops
        wr(8'hF2, 8'h00);
        wr(8'hF3, 8'h01);
        chk_irq("irq_stopped", 1'b0);
        wr(8'hF0, 8'h01);
        wr(8'hF2, 8'h03);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk_irq($sformatf("irq_oneshot_%0d", i), i == 8);
        end
        rd("ctrl_oneshot", 8'hF2, 8'h02);
        rd("count_oneshot", 8'hF1, 8'h00);
        rd("status_oneshot", 8'hF3, 8'h01);
        wr(8'hF2, 8'h00);
        chk_irq("irq_ie_clear", 1'b0);
        rd("status_after_ie", 8'hF3, 8'h01);
        wr(8'hF2, 8'h02);
        chk_irq("irq_ie_set", 1'b1);
        wr(8'hF3, 8'h01);
        repeat (20) @(posedge clk);
        #1;
        chk_irq("irq_no_more", 1'b0);
        rd("status_no_more", 8'hF3, 8'h00);
        rd("count_no_more", 8'hF1, 8'h00);

        // GPIO synchronizer and output register
        @(negedge clk);
        address = 8'hF5;
        gpio_in = 8'h5A;
        @(posedge clk);
        #1;
        check("gpio_in_edge1", data_out, 8'h00);
        @(posedge clk);
        #1;
        check("gpio_in_edge2", data_out, 8'h5A);
        wr(8'hF4, 8'hC3);
        check("gpio_out_wr", gpio_out, 8'hC3);
        rd("gpio_out_rd", 8'hF4, 8'hC3);

        // Mid-run reset clears I/O state but not RAM
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("gpio_out_after_rst", gpio_out, 8'h00);
        chk_irq("irq_after_rst", 1'b0);
        rd("reload_after_rst", 8'hF0, 8'h00);
        rd("ram_00_after_rst", 8'h00, 8'hA5);
        rd("ram_ef_after_rst", 8'hEF, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usermem_io.md
# usermem_io

Responder side of the CPU's user-memory bus. It holds a 240-byte data RAM and a 16-byte memory-mapped I/O page containing an 8-bit prescaled timer, an interrupt controller and a GPIO port. Its address, data and rw inputs connect to the CPU's usermem_address, usermem_data_out and rw outputs. Its data_out drives the CPU's usermem_data_in, and its interrupt output drives the CPU's interrupt input.

## Interface
- PRESCALE, 16: clock cycles per timer tick; legal range 1..256.
- IO_BASE, 8'hF0: first I/O address. RAM occupies 0x00..IO_BASE-1.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- address  input  8  byte address from the CPU.
- data_in  input  8  write data from the CPU.
- rw  input  1  1 = write this cycle, 0 = read.
- data_out  output  8  read data, combinational from address.
- interrupt  output  1  level interrupt request to the CPU.
- gpio_in  input  8  asynchronous external inputs.
- gpio_out  output  8  registered external outputs.

## Operation
- Address map, relative to IO_BASE:
  - +0 RELOAD, R/W. A write loads both RELOAD and COUNT.
  - +1 COUNT, read-only. Writes are ignored.
  - +2 CTRL, R/W. Bit0 EN, bit1 IE, bit2 AUTO. Bits 7:3 read as 0 and ignore writes.
  - +3 STATUS. Bit0 PEND. Writing 1 to bit0 clears PEND; writing 0 has no effect. Bits 7:1 read as 0.
  - +4 GPIO_OUT, R/W.
  - +5 GPIO_IN, read-only. Returns the synchronized gpio_in.
  - +6..+15 read 0x00; writes are ignored.
- RAM:
  - Write on a clock edge when rw=1 and address < IO_BASE.
  - Asynchronous read.
  - Contents are not reset.
- Reads have no side effects, including reads of STATUS.
- Prescaler:
  - An internal counter runs 0..PRESCALE-1 while EN=1 and asserts a tick in the cycle it equals PRESCALE-1, then wraps to 0.
  - It is held at 0 while EN=0.
- Timer behaviour on each tick:
  - If COUNT≠0, COUNT decrements by 1.
  - If COUNT=0, a timer event fires: PEND←1.
  - On an event with AUTO=1, COUNT←RELOAD.
  - On an event with AUTO=0, EN←0 and COUNT stays 0.
  - Event period is (RELOAD+1)·PRESCALE cycles. All arithmetic is 8-bit with no wrap below 0.
- interrupt = PEND & IE. It is asserted combinationally from registered state.
- GPIO_IN passes through a two-flop synchronizer.

## Timing
- Reset (reset=0 at an edge) clears the following; RAM is untouched:
  - RELOAD, COUNT, CTRL, PEND, GPIO_OUT and the prescaler all become 0.
  - Both synchronizer stages become 0.
  - Outputs after reset: interrupt=0, gpio_out=0x00, data_out=0x00 for any I/O address.
- Reset applied mid-count stops the timer immediately, and no event fires on that edge.
- Read latency is 0 cycles: data_out is valid in the same cycle as address.
- A written value is visible on data_out from the cycle after the write edge.
- A gpio_in change is visible in GPIO_IN 2 edges later.
- Simultaneous events:
  - STATUS clear and a timer event on the same edge: the event wins and PEND=1.
  - RELOAD write and a tick on the same edge: the write wins and COUNT←data_in.
  - CTRL write and an AUTO=0 event on the same edge: the CTRL write wins for EN, and PEND is still set.
  - Writing EN 1→0 resets the prescaler on that edge.
- interrupt rises in the cycle after the event edge. It falls in the cycle after the STATUS-clear edge, or after the IE-clear edge.

## Test plan
- Reset, then read 0xF0..0xFF → all 0x00, interrupt=0, gpio_out=0x00.
- Write 0x00=0xA5 and 0xEF=0x3C, then read both → 0xA5 and 0x3C; reading 0xF6 → 0x00.
- With PRESCALE=4: write RELOAD=2, then CTRL=0x07 → first interrupt rise exactly 12 cycles after the CTRL write edge. Write STATUS=0x01 → interrupt drops next cycle and re-rises 12 cycles after the previous rise.
- With AUTO=0, RELOAD=1, CTRL=0x03 → one event after 8 cycles, then CTRL reads 0x02 and COUNT stays 0 with no further events.
- Write STATUS=0x01 on the same edge as an event → PEND remains 1 and interrupt stays high.
- Drive gpio_in=0x5A → GPIO_IN reads 0x5A from the second edge on. Write GPIO_OUT=0xC3 → gpio_out=0xC3 next cycle. Pulse reset=0 → gpio_out=0x00 and RAM 0x00 still reads 0xA5.
